mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Round-robin arbiter that shares the single 32-bit memory bus among four requesters: I-cache fill, D-cache fill, D-cache writeback and the interrupt/DMA port. It issues registered one-hot grants and holds each grant for a whole transaction. It inserts programmable bus-turnaround dead cycles between owners and force-releases an owner that exceeds a tenure limit. Its `gnt`/`gnt_id` outputs drive the select lines of the bus datapath muxes built from the structural gate library.

## Interface
- `TURNAROUND`, default 1: dead cycles inserted after a release, in addition to the mandatory IDLE cycle; legal 0..3.
- `MAX_TENURE`, default 15: maximum cycles an owner may hold the bus; 0 disables the limit; legal 0..255.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  4  request per port; bit 0 = I-fill, 1 = D-fill, 2 = D-writeback, 3 = DMA/int. Level-sensitive.
- `done`  in  4  owner pulses its bit on the last transfer cycle; non-owner bits are ignored.
- `gnt`  out  4  one-hot registered grant; all-zero when the bus is unowned.
- `gnt_id`  out  2  encoded owner; valid only while `bus_busy`=1.
- `bus_busy`  out  1  high while any `gnt` bit is set.
- `timeout`  out  1  one-cycle pulse when an owner is force-released.

## Operation
- State machine has three states: IDLE, OWN, TURN. Reset state is IDLE.
- Reset values: `gnt`=0, `gnt_id`=0, `bus_busy`=0, `timeout`=0, rr pointer `ptr`=0, tenure counter=0, turnaround counter=0.
- **IDLE** (`gnt`=0):
  - If `req`≠0, select the first set bit scanning `ptr`, `ptr`+1, … mod 4.
  - Register `gnt`/`gnt_id`, clear the tenure counter to 1, go to OWN.
  - If `req`=0, stay in IDLE.
- **OWN**: grant is held and the tenure counter increments each cycle (8-bit, saturating). Release conditions are evaluated at each edge, in priority order:
  1. `done[gnt_id]`=1 → normal release.
  2. `req[gnt_id]`=0 → abandon release (no error).
  3. `MAX_TENURE`≠0 and tenure==`MAX_TENURE` → forced release; `timeout`=1 for the following cycle.
- On any release:
  - `gnt` goes to 0 next cycle.
  - `ptr` ← (`gnt_id`+1) mod 4.
  - Go to TURN if `TURNAROUND`>0, else go to IDLE.
- **TURN** (`gnt`=0): the turnaround counter loads `TURNAROUND` and decrements each cycle; go to IDLE when it reaches 1. Requests are ignored during TURN.
- Simultaneous events:
  - `done` and tenure limit in the same cycle → normal release; no `timeout`.
  - `done` and `req` drop in the same cycle → single release.
  - Requests arriving during OWN/TURN wait; no request is queued or latched. Arbitration always uses the live `req` in IDLE.
- Fairness: a port that holds `req` high is granted within 3 other tenures.
- Reset asserted mid-transaction: `gnt` drops asynchronously in the same cycle and the FSM returns to IDLE with `ptr`=0.

## Timing
- Request to grant from IDLE: `req` sampled at edge E, `gnt` high after E (1-cycle latency).
- Release: `done` sampled at edge R, `gnt`=0 after R. The next grant is visible no earlier than after edge R+1+`TURNAROUND`, so there are 1+`TURNAROUND` bus-dead cycles.
- With `MAX_TENURE`=N, the owner holds `gnt` for exactly N cycles when it never pulses `done`.
- `timeout` is registered and coincides with the first dead cycle.
- `gnt`, `gnt_id`, `bus_busy` and `timeout` are all flop outputs with no combinational input-to-output path.

## Test plan
- **Basic grant and release.** Reset, then `req`=0001, `done[0]` pulsed 3 cycles after the grant.
  - Expect `gnt`=0001 one cycle after `req`, held 4 cycles.
  - Expect `gnt`=0 for 2 cycles (`TURNAROUND`=1), `ptr`=1.
- **Round-robin rotation.** `req`=1111 held, each owner pulses `done` on its 2nd grant cycle.
  - Expect grant order 0,1,2,3,0 with `gnt_id` 0,1,2,3,0.
  - Expect exactly 2 dead cycles between grants.
- **Tenure limit.** `MAX_TENURE`=4, `req`=0100 held, `done` never asserted.
  - Expect `gnt`=0100 for exactly 4 cycles.
  - Expect `timeout`=1 for one cycle, then `gnt` re-granted to port 2 after the turnaround.
- **Tie-breaks.**
  - `done[1]` and the tenure limit coincide → no `timeout`.
  - `done[3]` pulsed while port 1 owns → ignored, grant unchanged.
- **Abandon and TURN behaviour.**
  - Port 2 drops `req` mid-tenure → `gnt`=0 next cycle, no `timeout`.
  - `req` raised during TURN only → no grant until IDLE.
  - `TURNAROUND`=0 → a single dead cycle.
- **Reset mid-tenure.** Assert `reset` asynchronously between edges while `gnt`=0010.
  - Expect `gnt`=0 and `bus_busy`=0 before the next edge.
  - After release with `req`=1010, expect first grant to port 1 (`ptr`=0 scan).

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner arbiter for the shared 32-bit memory bus.
// Registered one-hot grants, turnaround dead cycles, tenure limit.
module mem_bus_arbiter #(
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_TENURE = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       bus_busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  localparam logic [7:0] TEN_MAX  = 8'(MAX_TENURE);
  localparam logic [1:0] TURN_LD  = 2'(TURNAROUND);
  localparam logic       LIMIT_EN = (MAX_TENURE != 0);
  localparam logic       TURN_EN  = (TURNAROUND != 0);

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] ten_q, ten_d;
  logic [1:0] turn_q, turn_d;

  logic       pick_vld;
  logic [1:0] pick_id;
  logic [1:0] scan_idx;
  logic       rel_done;
  logic       rel_abn;
  logic       rel_lim;
  logic       rel_any;
  logic [7:0] ten_inc;

  // Scan from ptr upward; walking offsets high-to-low lets the
  // nearest requester overwrite the farther ones.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = ptr_q;
    scan_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = ptr_q + 2'(i);
      if (req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_id  = scan_idx;
      end
    end
  end

  always_comb begin
    rel_done = done[gnt_id_q];
    rel_abn  = ~req[gnt_id_q];
    rel_lim  = LIMIT_EN && (ten_q == TEN_MAX);
    rel_any  = rel_done | rel_abn | rel_lim;
    ten_inc  = (ten_q == 8'hFF) ? ten_q : ten_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    ten_d     = ten_q;
    turn_d    = turn_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d    = 4'b0001 << pick_id;
          gnt_id_d = pick_id;
          busy_d   = 1'b1;
          ten_d    = 8'd1;
          state_d  = OWN;
        end
      end
      OWN: begin
        if (rel_any) begin
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          ptr_d     = gnt_id_q + 2'd1;
          ten_d     = 8'd0;
          // Only a pure limit hit counts as a forced release.
          timeout_d = rel_lim & ~rel_done & ~rel_abn;
          if (TURN_EN) begin
            state_d = TURN;
            turn_d  = TURN_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ten_d = ten_inc;
        end
      end
      TURN: begin
        if (turn_q <= 2'd1) begin
          turn_d  = 2'd0;
          state_d = IDLE;
        end else begin
          turn_d = turn_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      ten_q     <= 8'd0;
      turn_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      ten_q     <= ten_d;
      turn_q    <= turn_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign bus_busy = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected tenures are queued
// by the stimulus and checked by a monitor at each bus release.
module tb_mem_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  int         sel;

  logic [3:0] g0, g1, g2;
  logic [1:0] i0, i1, i2;
  logic       b0, b1, b2;
  logic       t0, t1, t2;

  logic [3:0] mon_gnt;
  logic [1:0] mon_id;
  logic       mon_busy;
  logic       mon_to;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    int         held;
    int         dead;
    bit         to;
  } ten_t;

  ten_t exp_q[$];

  mem_bus_arbiter d0 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(g0), .gnt_id(i0), .bus_busy(b0), .timeout(t0)
  );

  mem_bus_arbiter #(.TURNAROUND(1), .MAX_TENURE(4)) d1 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(g1), .gnt_id(i1), .bus_busy(b1), .timeout(t1)
  );

  mem_bus_arbiter #(.TURNAROUND(0), .MAX_TENURE(15)) d2 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(g2), .gnt_id(i2), .bus_busy(b2), .timeout(t2)
  );

  always_comb begin
    mon_gnt  = g0;
    mon_id   = i0;
    mon_busy = b0;
    mon_to   = t0;
    case (sel)
      1: begin
        mon_gnt = g1; mon_id = i1; mon_busy = b1; mon_to = t1;
      end
      2: begin
        mon_gnt = g2; mon_id = i2; mon_busy = b2; mon_to = t2;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  // Monitor
  logic       prev_busy;
  int         dead_cnt;
  int         held_cnt;
  int         cur_dead;
  logic [3:0] cur_gnt;
  logic [1:0] cur_id;

  initial begin
    prev_busy = 1'b0;
    dead_cnt  = -1;
    held_cnt  = 0;
    cur_dead  = -1;
    cur_gnt   = 4'b0;
    cur_id    = 2'd0;
  end

  always @(negedge clk) begin
    ten_t e;
    if (reset) begin
      prev_busy = 1'b0;
      dead_cnt  = -1;
      held_cnt  = 0;
    end else begin
      checks++;
      if (mon_busy !== (mon_gnt != 4'b0)) begin
        errors++;
        $display("FAIL busy_vs_gnt: busy=%b gnt=%b", mon_busy, mon_gnt);
      end
      if (mon_busy) begin
        if (!prev_busy) begin
          cur_gnt  = mon_gnt;
          cur_id   = mon_id;
          cur_dead = dead_cnt;
          held_cnt = 1;
        end else begin
          held_cnt++;
          checks++;
          if (mon_gnt !== cur_gnt) begin
            errors++;
            $display("FAIL gnt_stable: got %b want %b", mon_gnt, cur_gnt);
          end
        end
        checks++;
        if (mon_to !== 1'b0) begin
          errors++;
          $display("FAIL timeout_while_busy: got %b want 0", mon_to);
        end
      end else if (prev_busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tenure: gnt=%b held=%0d", cur_gnt, held_cnt);
        end else begin
          e = exp_q.pop_front();
          checks += 4;
          if (cur_gnt !== e.gnt) begin
            errors++;
            $display("FAIL tenure_gnt: got %b want %b", cur_gnt, e.gnt);
          end
          if (cur_id !== e.id) begin
            errors++;
            $display("FAIL tenure_id: got %0d want %0d", cur_id, e.id);
          end
          if (held_cnt != e.held) begin
            errors++;
            $display("FAIL tenure_held: got %0d want %0d", held_cnt, e.held);
          end
          if (mon_to !== e.to) begin
            errors++;
            $display("FAIL tenure_timeout: got %b want %b", mon_to, e.to);
          end
          if (e.dead >= 0) begin
            checks++;
            if (cur_dead != e.dead) begin
              errors++;
              $display("FAIL dead_cycles: got %0d want %0d", cur_dead, e.dead);
            end
          end
        end
        dead_cnt = 1;
      end else begin
        if (dead_cnt >= 0) dead_cnt++;
        checks++;
        if (mon_to !== 1'b0) begin
          errors++;
          $display("FAIL spurious_timeout: got %b want 0", mon_to);
        end
      end
      prev_busy = mon_busy;
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] id,
                      input int held, input int dead, input bit to);
    ten_t e;
    e.gnt  = g;
    e.id   = id;
    e.held = held;
    e.dead = dead;
    e.to   = to;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_reset(input int s);
    sel   = s;
    req   = 4'b0;
    done  = 4'b0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_gnt", 8'(mon_gnt), 8'h0);
    check("rst_id", 8'(mon_id), 8'h0);
    check("rst_busy", 8'(mon_busy), 8'h0);
    check("rst_timeout", 8'(mon_to), 8'h0);
    reset = 1'b0;
  endtask

  task automatic wait_grant();
    for (int n = 0; n < 20 && !mon_busy; n++) tick();
    if (!mon_busy) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: no grant within 20 cycles");
    end
  endtask

  task automatic wait_release();
    for (int n = 0; n < 20 && mon_busy; n++) tick();
    if (mon_busy) begin
      checks++;
      errors++;
      $display("FAIL release_wait: no release within 20 cycles");
    end
  endtask

  task automatic own(input logic [3:0] m, input int k);
    wait_grant();
    repeat (k - 1) tick();
    done = m;
    tick();
    done = 4'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel    = 0;
    req    = 4'b0;
    done   = 4'b0;
    reset  = 1'b1;

    // Basic grant, then ptr=1 makes port 3 win over port 0
    do_reset(0);
    push(4'b0001, 2'd0, 4, -1, 1'b0);
    req = 4'b0001;
    own(4'b0001, 4);
    req = 4'b0000;
    push(4'b1000, 2'd3, 2, 2, 1'b0);
    req = 4'b1001;
    own(4'b1000, 2);
    req = 4'b0000;
    repeat (3) tick();

    // Rotation with all requesters active
    do_reset(0);
    push(4'b0001, 2'd0, 2, -1, 1'b0);
    push(4'b0010, 2'd1, 2, 2, 1'b0);
    push(4'b0100, 2'd2, 2, 2, 1'b0);
    push(4'b1000, 2'd3, 2, 2, 1'b0);
    push(4'b0001, 2'd0, 2, 2, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) own(4'b0001 << (i % 4), 2);
    req = 4'b0000;
    repeat (3) tick();

    // Non-owner done is ignored
    push(4'b0010, 2'd1, 4, -1, 1'b0);
    req = 4'b0010;
    wait_grant();
    tick();
    done = 4'b1000;
    tick();
    done = 4'b0000;
    tick();
    done = 4'b0010;
    tick();
    done = 4'b0000;
    req  = 4'b0000;
    repeat (3) tick();

    // Abandon mid-tenure
    push(4'b0100, 2'd2, 2, -1, 1'b0);
    req = 4'b0100;
    wait_grant();
    tick();
    req = 4'b0000;
    tick();
    repeat (3) tick();

    // Request raised only during TURN
    push(4'b0001, 2'd0, 1, -1, 1'b0);
    req = 4'b0001;
    own(4'b0001, 1);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    repeat (4) tick();
    check("turn_ignored", 8'(mon_busy), 8'h0);

    // Reset mid-tenure clears ptr
    do_reset(0);
    push(4'b0100, 2'd2, 1, -1, 1'b0);
    req = 4'b0100;
    own(4'b0100, 1);
    req = 4'b0010;
    wait_grant();
    check("pre_rst_gnt", 8'(mon_gnt), 8'h02);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_gnt", 8'(mon_gnt), 8'h0);
    check("async_busy", 8'(mon_busy), 8'h0);
    req = 4'b1010;
    tick();
    reset = 1'b0;
    push(4'b0010, 2'd1, 2, -1, 1'b0);
    own(4'b0010, 2);
    req = 4'b0000;
    repeat (3) tick();

    // Tenure limit of 4
    do_reset(1);
    push(4'b0100, 2'd2, 4, -1, 1'b1);
    push(4'b0100, 2'd2, 4, 2, 1'b1);
    req = 4'b0100;
    wait_grant();
    wait_release();
    wait_grant();
    wait_release();
    req = 4'b0000;
    repeat (3) tick();

    // done coincides with the limit
    push(4'b0010, 2'd1, 4, -1, 1'b0);
    req = 4'b0010;
    own(4'b0010, 4);
    req = 4'b0000;
    repeat (3) tick();

    // Zero turnaround: one dead cycle
    do_reset(2);
    push(4'b0001, 2'd0, 1, -1, 1'b0);
    push(4'b0010, 2'd1, 1, 1, 1'b0);
    req = 4'b0011;
    own(4'b0001, 1);
    own(4'b0010, 1);
    req = 4'b0000;
    repeat (4) tick();

    check("queue_empty", 8'(exp_q.size()), 8'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
